// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, instruction kinds and the symbolic-to-binary encoder.
// Both the controller and the instruction writer decode/encode through these definitions.
package mips_pkg;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpRtype = 6'b000000;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctSlt = 6'b101010;
    localparam logic [5:0] FunctMul = 6'b011100;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b100;
    localparam logic [2:0] AluSlt = 3'b110;
    localparam logic [2:0] AluMul = 3'b101;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;

    typedef enum logic [2:0] {
        KindLw    = 3'd0,
        KindSw    = 3'd1,
        KindAddi  = 3'd2,
        KindBeq   = 3'd3,
        KindJ     = 3'd4,
        KindRtype = 3'd5
    } kind_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    function automatic enc_t encode_instr(
        input logic [2:0]  kind,
        input logic [2:0]  alu,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        enc_t       e;
        logic [5:0] funct;
        logic       funct_ok;
        e.legal  = 1'b1;
        e.word   = '0;
        funct    = '0;
        funct_ok = 1'b1;
        case (alu)
            AluAdd:  funct = FunctAdd;
            AluSub:  funct = FunctSub;
            AluSlt:  funct = FunctSlt;
            AluMul:  funct = FunctMul;
            AluAnd:  funct = FunctAnd;
            AluOr:   funct = FunctOr;
            default: funct_ok = 1'b0;
        endcase
        case (kind)
            KindLw:    e.word = {OpLw, rs, rt, imm};
            KindSw:    e.word = {OpSw, rs, rt, imm};
            KindAddi:  e.word = {OpAddi, rs, rt, imm};
            KindBeq:   e.word = {OpBeq, rs, rt, imm};
            KindJ:     e.word = {OpJ, target};
            KindRtype: begin
                e.word  = {OpRtype, rs, rt, rd, 5'b00000, funct};
                e.legal = funct_ok;
            end
            default:   e.legal = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata_o shows the head whenever not empty.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_writer.sv
// Encodes symbolic instructions into MIPS words, queues them and writes them
// sequentially into instruction memory from word address 0.
module instr_encoder_writer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_kind_i,
    input  logic [2:0]        in_alu_i,
    input  logic [4:0]        in_rs_i,
    input  logic [4:0]        in_rt_i,
    input  logic [4:0]        in_rd_i,
    input  logic [15:0]       in_imm_i,
    input  logic [25:0]       in_target_i,
    output logic              mem_we_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              err_o,
    output logic              prog_full_o,
    output logic [ADDR_W:0]   words_written_o
);

    enc_t            enc;
    logic            accept, push, pop;
    logic            fifo_full, fifo_empty;
    logic [31:0]     fifo_head;
    logic [ADDR_W:0] accept_cnt_q, accept_cnt_d;
    logic [ADDR_W:0] written_q, written_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic            err_q, err_d;

    assign enc = encode_instr(in_kind_i, in_alu_i, in_rs_i, in_rt_i, in_rd_i,
                              in_imm_i, in_target_i);

    // The counter saturates at 2^ADDR_W, so its top bit alone marks a full program.
    assign prog_full_o = accept_cnt_q[ADDR_W];
    assign in_ready_o  = !fifo_full && !prog_full_o && !start_i;
    assign accept      = in_valid_i && in_ready_o;
    assign push        = accept && enc.legal;
    assign pop         = mem_we_o && mem_ready_i;

    assign mem_we_o        = !fifo_empty;
    assign mem_wdata_o     = fifo_empty ? 32'h0 : fifo_head;
    assign mem_addr_o      = addr_q;
    assign err_o           = err_q;
    assign words_written_o = written_q;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (start_i),
        .push_i  (push),
        .wdata_i (enc.word),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        accept_cnt_d = accept_cnt_q;
        written_d    = written_q;
        addr_d       = addr_q;
        err_d        = err_q;
        if (start_i) begin
            accept_cnt_d = '0;
            written_d    = '0;
            addr_d       = '0;
            err_d        = 1'b0;
        end else begin
            if (push)                  accept_cnt_d = accept_cnt_q + 1'b1;
            if (accept && !enc.legal)  err_d        = 1'b1;
            if (pop) begin
                addr_d    = addr_q + 1'b1;
                written_d = written_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            accept_cnt_q <= '0;
            written_q    <= '0;
            addr_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            accept_cnt_q <= accept_cnt_d;
            written_q    <= written_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Randomized bench for instr_encoder_writer: a default instance plus a 4-word (ADDR_W=2)
// instance for the capacity case, checked against a plain encoding model and write log.
module tb_instr_encoder_writer;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, mem_ready;
    logic [2:0]  in_kind, in_alu;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, mem_we, err, prog_full;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  words_written;

    logic        s_in_ready, s_mem_we, s_err, s_prog_full;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_words_written;

    int n_tests = 0;
    int n_fail  = 0;

    int          wr_addr[$], s_wr_addr[$];
    logic [31:0] wr_data[$], s_wr_data[$];

    logic [2:0]  q_kind[8], q_alu[8];
    logic [4:0]  q_rs[8], q_rt[8], q_rd[8];
    logic [15:0] q_imm[8];
    logic [25:0] q_tgt[8];
    logic [31:0] q_exp[8];
    logic [2:0]  alu_tab[6] = '{3'b010, 3'b100, 3'b110, 3'b101, 3'b000, 3'b001};

    always #5 clk = ~clk;

    instr_encoder_writer #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_kind_i(in_kind), .in_alu_i(in_alu), .in_rs_i(in_rs), .in_rt_i(in_rt),
        .in_rd_i(in_rd), .in_imm_i(in_imm), .in_target_i(in_target), .mem_we_o(mem_we),
        .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .err_o(err), .prog_full_o(prog_full), .words_written_o(words_written)
    );

    instr_encoder_writer #(.DEPTH(4), .ADDR_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(s_in_ready), .in_kind_i(in_kind), .in_alu_i(in_alu), .in_rs_i(in_rs),
        .in_rt_i(in_rt), .in_rd_i(in_rd), .in_imm_i(in_imm), .in_target_i(in_target),
        .mem_we_o(s_mem_we), .mem_ready_i(mem_ready), .mem_addr_o(s_mem_addr),
        .mem_wdata_o(s_mem_wdata), .err_o(s_err), .prog_full_o(s_prog_full),
        .words_written_o(s_words_written)
    );

    // Memory side: log every completed write handshake.
    always @(posedge clk) begin
        if (mem_we && mem_ready) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(mem_wdata);
        end
        if (s_mem_we && mem_ready) begin
            s_wr_addr.push_back(int'(s_mem_addr));
            s_wr_data.push_back(s_mem_wdata);
        end
    end

    // Reference encoder: returns {legal, word}.
    function automatic logic [32:0] model_enc(input logic [2:0] k, input logic [2:0] a,
                                              input logic [4:0] s, input logic [4:0] t,
                                              input logic [4:0] d, input logic [15:0] im,
                                              input logic [25:0] tg);
        logic [5:0] f;
        logic       ok;
        ok = 1'b1;
        f  = 6'h00;
        case (a)
            3'b010:  f = 6'h20;
            3'b100:  f = 6'h22;
            3'b110:  f = 6'h2a;
            3'b101:  f = 6'h1c;
            3'b000:  f = 6'h24;
            3'b001:  f = 6'h25;
            default: ok = 1'b0;
        endcase
        case (k)
            3'd0:    return {1'b1, 6'h23, s, t, im};
            3'd1:    return {1'b1, 6'h2b, s, t, im};
            3'd2:    return {1'b1, 6'h08, s, t, im};
            3'd3:    return {1'b1, 6'h04, s, t, im};
            3'd4:    return {1'b1, 6'h02, tg};
            3'd5:    return {ok, 6'h00, s, t, d, 5'd0, f};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    task automatic drive(input logic [2:0] k, input logic [2:0] a, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [15:0] im,
                         input logic [25:0] tg);
        in_kind = k; in_alu = a; in_rs = s; in_rt = t; in_rd = d; in_imm = im; in_target = tg;
    endtask

    task automatic gen_legal(input int i);
        logic [32:0] r;
        q_kind[i] = 3'($urandom_range(0, 5));
        q_alu[i]  = alu_tab[$urandom_range(0, 5)];
        q_rs[i]   = 5'($urandom); q_rt[i] = 5'($urandom); q_rd[i] = 5'($urandom);
        q_imm[i]  = 16'($urandom); q_tgt[i] = 26'($urandom);
        r = model_enc(q_kind[i], q_alu[i], q_rs[i], q_rt[i], q_rd[i], q_imm[i], q_tgt[i]);
        q_exp[i] = r[31:0];
    endtask

    task automatic drive_q(input int i);
        drive(q_kind[i], q_alu[i], q_rs[i], q_rt[i], q_rd[i], q_imm[i], q_tgt[i]);
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wr_addr.delete(); wr_data.delete(); s_wr_addr.delete(); s_wr_data.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        drive(3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        repeat (2) @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_tests++; if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_tests++; if (prog_full !== 1'b0) begin n_fail++; $display("FAIL reset_prog_full got %b want 0", prog_full); end
        n_tests++; if (words_written !== 9'd0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words_written); end
        rst = 1'b0;
    endtask

    task automatic test_rtype_add;
        pulse_start();
        mem_ready = 1'b1;
        drive(3'd5, 3'b010, 5'd1, 5'd2, 5'd3, 16'($urandom), 26'($urandom));
        in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        n_tests++; if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 32'h00221820) begin
            n_fail++; $display("FAIL add_word got we=%b addr=%0d data=%h want 1/0/00221820", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_tests++; if (words_written !== 9'd1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL add_written got words=%0d we=%b want 1/0", words_written, mem_we);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp[4] = '{32'h8D280004, 32'h1022FFFF, 32'h08000010, 32'h00A6201C};
        pulse_start();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(3'd0, 3'($urandom), 5'd9, 5'd8, 5'($urandom), 16'd4, 26'($urandom));
                1: drive(3'd3, 3'($urandom), 5'd1, 5'd2, 5'($urandom), 16'hFFFF, 26'($urandom));
                2: drive(3'd4, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                         16'($urandom), 26'h10);
                default: drive(3'd5, 3'b101, 5'd5, 5'd6, 5'd4, 16'($urandom), 26'($urandom));
            endcase
            in_valid = 1'b1;
            @(negedge clk);
            n_tests++; if (mem_we !== 1'b1 || mem_addr !== 8'(i) || mem_wdata !== exp[i]) begin
                n_fail++; $display("FAIL b2b_word%0d got we=%b addr=%0d data=%h want 1/%0d/%h",
                                   i, mem_we, mem_addr, mem_wdata, i, exp[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (words_written !== 9'd4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", words_written); end
    endtask

    task automatic test_stall;
        int  k = 0;
        logic acc;
        pulse_start();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) gen_legal(i);
        for (int c = 0; c < 40 && (k < 5 || mem_we); c++) begin
            if (c == 8) begin
                n_tests++; if (k !== 4 || in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL stall_fill got accepts=%0d ready=%b want 4/0", k, in_ready);
                end
                n_tests++; if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== q_exp[0]) begin
                    n_fail++; $display("FAIL stall_hold got we=%b addr=%0d data=%h want 1/0/%h",
                                       mem_we, mem_addr, mem_wdata, q_exp[0]);
                end
                mem_ready = 1'b1;
            end
            if (k < 5) begin drive_q(k); in_valid = 1'b1; end else in_valid = 1'b0;
            #1 acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) k++;
        end
        in_valid = 1'b0;
        n_tests++; if (wr_data.size() !== 5 || words_written !== 9'd5) begin
            n_fail++; $display("FAIL stall_count got writes=%0d words=%0d want 5/5", wr_data.size(), words_written);
        end
        for (int i = 0; i < 5 && i < wr_data.size(); i++) begin
            n_tests++; if (wr_addr[i] !== i || wr_data[i] !== q_exp[i]) begin
                n_fail++; $display("FAIL stall_write%0d got addr=%0d data=%h want %0d/%h",
                                   i, wr_addr[i], wr_data[i], i, q_exp[i]);
            end
        end
    endtask

    task automatic test_illegal;
        logic [32:0] r;
        pulse_start();
        mem_ready = 1'b1;
        drive(3'd6, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
        in_valid = 1'b1;
        @(negedge clk);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_kind_err got %b want 1", err); end
        drive(3'd5, 3'b011, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (err !== 1'b1 || mem_we !== 1'b0 || words_written !== 9'd0 || wr_data.size() !== 0) begin
            n_fail++; $display("FAIL illegal_dropped got err=%b we=%b words=%0d writes=%0d want 1/0/0/0",
                               err, mem_we, words_written, wr_data.size());
        end
        drive(3'd2, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
        r = model_enc(in_kind, in_alu, in_rs, in_rt, in_rd, in_imm, in_target);
        in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (wr_data.size() !== 1 || words_written !== 9'd1 || err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_then_addi got writes=%0d words=%0d err=%b want 1/1/1",
                               wr_data.size(), words_written, err);
        end else begin
            n_tests++; if (wr_addr[0] !== 0 || wr_data[0] !== r[31:0]) begin
                n_fail++; $display("FAIL illegal_addi_word got addr=%0d data=%h want 0/%h", wr_addr[0], wr_data[0], r[31:0]);
            end
        end
    endtask

    task automatic test_capacity;
        int   k = 0;
        logic acc;
        pulse_start();
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) gen_legal(i);
        for (int c = 0; c < 12; c++) begin
            if (k < 5) drive_q(k);
            in_valid = 1'b1;
            #1 acc = s_in_ready;
            @(negedge clk);
            if (acc) k++;
        end
        n_tests++; if (k !== 4 || s_prog_full !== 1'b1 || s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL cap_full got accepts=%0d full=%b ready=%b want 4/1/0", k, s_prog_full, s_in_ready);
        end
        n_tests++; if (s_words_written !== 3'd4 || s_mem_addr !== 2'd0 || s_mem_we !== 1'b0) begin
            n_fail++; $display("FAIL cap_wrap got words=%0d addr=%0d we=%b want 4/0/0",
                               s_words_written, s_mem_addr, s_mem_we);
        end
        for (int i = 0; i < 4 && i < s_wr_data.size(); i++) begin
            n_tests++; if (s_wr_addr[i] !== i || s_wr_data[i] !== q_exp[i]) begin
                n_fail++; $display("FAIL cap_write%0d got addr=%0d data=%h want %0d/%h",
                                   i, s_wr_addr[i], s_wr_data[i], i, q_exp[i]);
            end
        end
        @(negedge clk); start = 1'b1;
        #1;
        n_tests++; if (s_in_ready !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL cap_start_ready got s=%b big=%b want 0/0", s_in_ready, in_ready);
        end
        @(negedge clk); start = 1'b0;
        n_tests++; if (s_prog_full !== 1'b0 || s_words_written !== 3'd0 || s_mem_we !== 1'b0) begin
            n_fail++; $display("FAIL cap_cleared got full=%b words=%0d we=%b want 0/0/0",
                               s_prog_full, s_words_written, s_mem_we);
        end
        @(negedge clk); in_valid = 1'b0;
        n_tests++; if (s_mem_we !== 1'b1 || s_mem_addr !== 2'd0 || s_mem_wdata !== q_exp[4]) begin
            n_fail++; $display("FAIL cap_fifth got we=%b addr=%0d data=%h want 1/0/%h",
                               s_mem_we, s_mem_addr, s_mem_wdata, q_exp[4]);
        end
        @(negedge clk);
    endtask

    task automatic test_flush(input bit use_rst);
        pulse_start();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gen_legal(i); drive_q(i); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL flush_pre got we=%b want 1", mem_we); end
        wr_data.delete(); wr_addr.delete();
        if (use_rst) rst = 1'b1; else start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_tests++; if (mem_we !== 1'b0 || mem_addr !== 8'd0 || words_written !== 9'd0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL flush_%s got we=%b addr=%0d words=%0d data=%h want 0/0/0/0",
                               use_rst ? "rst" : "start", mem_we, mem_addr, words_written, mem_wdata);
        end
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if (wr_data.size() !== 0 || words_written !== 9'd0) begin
            n_fail++; $display("FAIL flush_%s_leak got writes=%0d words=%0d want 0/0",
                               use_rst ? "rst" : "start", wr_data.size(), words_written);
        end
    endtask

    task automatic test_random;
        logic [31:0] exp_q[$];
        logic [32:0] r;
        logic        err_exp = 1'b0;
        pulse_start();
        for (int c = 0; c < 300; c++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            drive(3'($urandom_range(0, 7)), 3'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 16'($urandom), 26'($urandom));
            #1;
            if (in_valid && in_ready) begin
                r = model_enc(in_kind, in_alu, in_rs, in_rt, in_rd, in_imm, in_target);
                if (r[32]) exp_q.push_back(r[31:0]); else err_exp = 1'b1;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 20 && mem_we; c++) @(negedge clk);
        n_tests++; if (wr_data.size() !== exp_q.size() || words_written !== 9'(exp_q.size()) || err !== err_exp) begin
            n_fail++; $display("FAIL rand_totals got writes=%0d words=%0d err=%b want %0d/%0d/%b",
                               wr_data.size(), words_written, err, exp_q.size(), exp_q.size(), err_exp);
        end
        for (int i = 0; i < exp_q.size() && i < wr_data.size(); i++) begin
            n_tests++; if (wr_addr[i] !== i || wr_data[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_write%0d got addr=%0d data=%h want %0d/%h",
                                   i, wr_addr[i], wr_data[i], i, exp_q[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rtype_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_capacity();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
